// File: rtl/sha3_pad_chunker.sv
`timescale 1ns/1ps
// sha3_pad_chunker
// Absorb-side front end of the SHA3 permutation engine. Collects a message
// byte stream into one sponge-rate block, applies SHA3 domain padding
// (DSBYTE ... 0x80) and emits each 1600-bit block as eight 200-bit chunks.
// Capacity bytes are always emitted as zero. Blocks are spaced at least
// GAP_CYCLES apart (first chunk to first chunk) so the permutation can finish.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low reset
//   in_valid   : input beat valid
//   in_ready   : beat accepted this cycle (only while collecting bytes)
//   in_data    : message byte
//   in_bvalid  : in_data carries a byte (0 = end-only beat, needs in_last)
//   in_last    : beat ends the message
//   pushout    : doutix/dout valid this cycle
//   doutix     : chunk index 0..7
//   dout       : chunk data, zero when pushout=0
//   blk_first  : chunk belongs to the first block of a message
//   blk_last   : chunk belongs to the final (padded) block of a message
module sha3_pad_chunker #(
  parameter int         RATE_BYTES = 136,
  parameter logic [7:0] DSBYTE     = 8'h06,
  parameter int         GAP_CYCLES = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_bvalid,
  input  logic         in_last,
  output logic         pushout,
  output logic [2:0]   doutix,
  output logic [199:0] dout,
  output logic         blk_first,
  output logic         blk_last
);

  localparam int             CW       = $clog2(RATE_BYTES + 1);
  localparam int             GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int             GW       = $clog2(GAP_LOAD + 2);
  localparam logic [CW-1:0]  RATE_C   = CW'(RATE_BYTES);

  typedef enum logic [1:0] {S_FILL, S_WAIT, S_EMIT} state_t;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           count_reg, count_next;
  logic [GW-1:0]           gap_reg, gap_next;
  logic                    pad_pending_reg, pad_pending_next;
  logic                    first_reg, first_next;
  logic                    last_reg, last_next;
  logic [8*RATE_BYTES-1:0] buf_reg, buf_next;
  logic                    pushout_reg, pushout_next;
  logic [2:0]              doutix_reg, doutix_next;
  logic [199:0]            dout_reg, dout_next;
  logic                    blk_first_reg, blk_first_next;
  logic                    blk_last_reg, blk_last_next;

  logic [8*RATE_BYTES-1:0] buf_fill;   // buffer after accepting the current beat
  logic [8*RATE_BYTES-1:0] pad_blk;    // pad-only block used for the overflow case
  logic [1599:0]           blk_wide;   // full state-width view, capacity zeroed
  logic [199:0]            chunk [8];
  logic [CW-1:0]           p;          // byte count after this beat's byte, if any

  assign p        = count_reg + CW'(in_bvalid);
  assign in_ready = reset && (state_reg == S_FILL);

  // Per-byte write/pad logic. Bytes at or beyond the current count are known
  // to be zero, so padding can be applied with XOR; when p = RATE-1 the two
  // pad bytes collide and give DSBYTE ^ 0x80.
  genvar gi;
  generate
    for (gi = 0; gi < RATE_BYTES; gi++) begin : g_byte
      localparam logic [CW-1:0] IDX = CW'(gi);
      logic [7:0] wr_byte;
      assign wr_byte = (in_bvalid && count_reg == IDX) ? in_data : buf_reg[gi*8 +: 8];
      assign buf_fill[gi*8 +: 8] = wr_byte
          ^ ((in_last && p == IDX) ? DSBYTE : 8'h00)
          ^ ((in_last && p != RATE_C && gi == RATE_BYTES - 1) ? 8'h80 : 8'h00);
      assign pad_blk[gi*8 +: 8] = ((gi == 0) ? DSBYTE : 8'h00)
          ^ ((gi == RATE_BYTES - 1) ? 8'h80 : 8'h00);
    end
    for (gi = 0; gi < 200; gi++) begin : g_wide
      if (gi < RATE_BYTES) begin : g_rate
        assign blk_wide[gi*8 +: 8] = buf_reg[gi*8 +: 8];
      end else begin : g_cap
        assign blk_wide[gi*8 +: 8] = 8'h00;
      end
    end
    for (gi = 0; gi < 8; gi++) begin : g_chunk
      assign chunk[gi] = blk_wide[gi*200 +: 200];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_FILL;
      count_reg       <= '0;
      gap_reg         <= '0;
      pad_pending_reg <= 1'b0;
      first_reg       <= 1'b1;
      last_reg        <= 1'b0;
      buf_reg         <= '0;
      pushout_reg     <= 1'b0;
      doutix_reg      <= 3'd0;
      dout_reg        <= '0;
      blk_first_reg   <= 1'b0;
      blk_last_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      gap_reg         <= gap_next;
      pad_pending_reg <= pad_pending_next;
      first_reg       <= first_next;
      last_reg        <= last_next;
      buf_reg         <= buf_next;
      pushout_reg     <= pushout_next;
      doutix_reg      <= doutix_next;
      dout_reg        <= dout_next;
      blk_first_reg   <= blk_first_next;
      blk_last_reg    <= blk_last_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    count_next       = count_reg;
    gap_next         = (gap_reg != '0) ? gap_reg - 1'b1 : gap_reg;
    pad_pending_next = pad_pending_reg;
    first_next       = first_reg;
    last_next        = last_reg;
    buf_next         = buf_reg;
    pushout_next     = 1'b0;
    doutix_next      = 3'd0;
    blk_first_next   = 1'b0;
    blk_last_next    = 1'b0;

    case (state_reg)
      S_FILL: begin
        if (in_valid) begin
          buf_next   = buf_fill;
          count_next = p;
          if (in_last) begin
            state_next = S_WAIT;
            if (p != RATE_C) begin
              last_next = 1'b1;
            end else begin
              // Message ends exactly on a block boundary: send this block
              // unpadded and follow with a pad-only block.
              last_next        = 1'b0;
              pad_pending_next = 1'b1;
            end
          end else if (p == RATE_C) begin
            last_next  = 1'b0;
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (gap_reg == '0) begin
          // Chunk 0 is registered on the same edge that enters EMIT.
          state_next     = S_EMIT;
          gap_next       = GW'(GAP_LOAD);
          pushout_next   = 1'b1;
          doutix_next    = 3'd0;
          blk_first_next = first_reg;
          blk_last_next  = last_reg;
        end
      end
      S_EMIT: begin
        if (doutix_reg != 3'd7) begin
          pushout_next   = 1'b1;
          doutix_next    = doutix_reg + 3'd1;
          blk_first_next = blk_first_reg;
          blk_last_next  = blk_last_reg;
        end else begin
          count_next = '0;
          first_next = last_reg;
          if (pad_pending_reg) begin
            buf_next         = pad_blk;
            last_next        = 1'b1;
            pad_pending_next = 1'b0;
            state_next       = S_WAIT;
          end else begin
            buf_next   = '0;
            state_next = S_FILL;
          end
        end
      end
      default: state_next = S_FILL;
    endcase

    dout_next = pushout_next ? chunk[doutix_next] : '0;
  end

  assign pushout   = pushout_reg;
  assign doutix    = doutix_reg;
  assign dout      = dout_reg;
  assign blk_first = blk_first_reg;
  assign blk_last  = blk_last_reg;

endmodule

// File: tb/tb_sha3_pad_chunker.sv
`timescale 1ns/1ps
module tb_sha3_pad_chunker;

  localparam int RATE = 136;
  localparam int GAP  = 24;

  localparam logic [199:0] PAD5 = 200'h80_00000000_00000000_0000;
  localparam logic [199:0] K86  = 200'h86_00000000_00000000_0000;
  localparam logic [199:0] FF5  = 200'hFF_FFFFFFFF_FFFFFFFF_FFFF;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = 8'h00;
  logic         in_bvalid = 1'b0;
  logic         in_last = 1'b0;
  logic         pushout;
  logic [2:0]   doutix;
  logic [199:0] dout;
  logic         blk_first;
  logic         blk_last;

  sha3_pad_chunker #(.RATE_BYTES(RATE), .DSBYTE(8'h06), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_bvalid(in_bvalid), .in_last(in_last),
    .pushout(pushout), .doutix(doutix), .dout(dout),
    .blk_first(blk_first), .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   ix;
    logic [199:0] data;
    logic         first;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  int           c0_q[$];
  int           checks = 0;
  int           passes = 0;
  int           cyc = 0;
  int           prev_cyc = 0;
  exp_t         me;
  logic [1599:0] blk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [199:0] got, input logic [199:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  // Monitor: pops one expected chunk for every pushout cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (pushout) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_chunk: got doutix=%0d data=%h, expected no output", doutix, dout);
        end else begin
          me = exp_q.pop_front();
          $display("chunk ix=%0d first=%0d last=%0d data=%h", doutix, blk_first, blk_last, dout);
          chk("chunk_tag", {197'd0, doutix, blk_first, blk_last}, {197'd0, me.ix, me.first, me.last});
          chk("chunk_data", dout, me.data);
          if (doutix == 3'd0) c0_q.push_back(cyc);
          else chk("no_bubble", 200'(cyc - prev_cyc), 200'd1);
          prev_cyc = cyc;
        end
      end else begin
        chk("idle_dout_zero", dout, '0);
      end
    end
  end

  task automatic push_blk(input logic [1599:0] b, input logic f, input logic l);
    for (int c = 0; c < 8; c++) exp_q.push_back({3'(c), b[c*200 +: 200], f, l});
  endtask

  // Called at a negedge; returns at the negedge after the beat transferred.
  task automatic send(input logic bv, input logic [7:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1; in_bvalid = bv; in_data = d; in_last = last;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, expected 1", n);
    end
    @(negedge clk);
    in_valid = 1'b0; in_bvalid = 1'b0; in_last = 1'b0; in_data = 8'h00;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 200'(exp_q.size()), 200'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_abc();
    send(1'b1, 8'h61, 1'b0);
    send(1'b1, 8'h62, 1'b0);
    send(1'b1, 8'h63, 1'b1);
  endtask

  task automatic abc_blk(output logic [1599:0] b);
    b = '0;
    b[0 +: 200]    = 200'h06636261;
    b[1000 +: 200] = PAD5;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_pushout", pushout, 1'b0);
    chk("reset_doutix", doutix, 3'd0);
    chk("reset_dout", dout, '0);
    chk("reset_flags", {blk_first, blk_last}, 2'b00);
    chk("reset_in_ready", in_ready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1'b1);

    // "abc"
    $display("msg abc");
    abc_blk(blk);
    push_blk(blk, 1'b1, 1'b1);
    send_abc();
    drain();

    // Empty message
    $display("msg empty");
    blk = '0;
    blk[0 +: 200]    = 200'h06;
    blk[1000 +: 200] = PAD5;
    push_blk(blk, 1'b1, 1'b1);
    send(1'b0, 8'h00, 1'b1);
    drain();

    // 135 zero bytes: pad bytes collide into 0x86
    $display("msg 135x00");
    blk = '0;
    blk[1000 +: 200] = K86;
    push_blk(blk, 1'b1, 1'b1);
    for (int i = 0; i < 135; i++) send(1'b1, 8'h00, i == 134);
    drain();

    // 136 x 0xFF: full unpadded block then pad-only block
    $display("msg 136xFF");
    blk = '0;
    for (int c = 0; c < 5; c++) blk[c*200 +: 200] = {200{1'b1}};
    blk[1000 +: 200] = FF5;
    push_blk(blk, 1'b1, 1'b0);
    blk = '0;
    blk[0 +: 200]    = 200'h06;
    blk[1000 +: 200] = PAD5;
    push_blk(blk, 1'b0, 1'b1);
    c0_q.delete();
    for (int i = 0; i < 136; i++) send(1'b1, 8'hFF, i == 135);
    drain();
    chk("gap_chunk0_to_chunk0", (c0_q.size() == 2) ? 200'(c0_q[1] - c0_q[0]) : '1, 200'(GAP));

    // 60-byte message, gap-free then with a 10-cycle pause after byte 50
    blk = '0;
    for (int i = 0; i < 60; i++) blk[i*8 +: 8] = 8'(i + 1);
    blk[60*8 +: 8]  = 8'h06;
    blk[135*8 +: 8] = 8'h80;
    $display("msg 60 bytes gap-free");
    push_blk(blk, 1'b1, 1'b1);
    for (int i = 0; i < 60; i++) send(1'b1, 8'(i + 1), i == 59);
    drain();
    $display("msg 60 bytes paused");
    push_blk(blk, 1'b1, 1'b1);
    for (int i = 0; i < 60; i++) begin
      if (i == 50) begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk("ready_during_pause", in_ready, 1'b1);
        end
      end
      send(1'b1, 8'(i + 1), i == 59);
    end
    drain();

    // Reset during EMIT at doutix=3
    $display("msg abc with reset mid-emit");
    abc_blk(blk);
    push_blk(blk, 1'b1, 1'b1);
    send_abc();
    n = 0;
    while (!(pushout && doutix == 3'd3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("saw_doutix3", pushout && doutix == 3'd3, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("abort_pushout", pushout, 1'b0);
    chk("abort_dout", dout, '0);
    chk("abort_doutix", doutix, 3'd0);
    chk("abort_in_ready", in_ready, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", in_ready, 1'b1);
    abc_blk(blk);
    push_blk(blk, 1'b1, 1'b1);
    send_abc();
    drain();

    repeat (30) @(negedge clk);
    chk("final_queue_empty", 200'(exp_q.size()), 200'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sha3_pad_chunker.md
Name: sha3_pad_chunker

Overview:
- Absorb-side front end of the SHA3 perm engine.
- Takes a message byte stream and applies SHA3 domain padding (0x06 … 0x80) at the sponge rate.
- Emits each padded 1600-bit block as eight 200-bit chunks tagged with chunk index 0..7. These drive the perm engine's dix/din/pushin inputs directly.
- Capacity lanes are emitted as zero. State XOR across blocks is done downstream, using blk_first/blk_last.

Parameters:
- RATE_BYTES, 136: sponge rate in bytes (SHA3-256). Legal range 1..199.
- DSBYTE, 8'h06: domain-separation/pad-start byte.
- GAP_CYCLES, 24: minimum cycles between the first chunk of one block and the first chunk of the next block, so the perm engine can finish its rounds.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: byte/end-of-message strobe is valid.
- in_ready, output, 1: block accepts the input this cycle.
- in_data, input, 8: message byte.
- in_bvalid, input, 1: in_data carries a byte. When 0, this is an end-only beat; it is only legal with in_last=1 and is used for empty or already-flushed messages.
- in_last, input, 1: this beat ends the message.
- pushout, output, 1: doutix/dout are valid this cycle.
- doutix, output, 3: chunk index 0..7.
- dout, output, 200: chunk data.
- blk_first, output, 1: qualified by pushout; chunk belongs to the first block of a message.
- blk_last, output, 1: qualified by pushout; chunk belongs to the final (padded) block of a message.

Behaviour:
- Reset (reset=0, async):
  - pushout=0, doutix=0, dout=0, blk_first=0, blk_last=0, in_ready=0 while asserted.
  - Buffer cleared, byte count=0, first_flag=1, gap counter=0, state FILL.
  - Reset mid-EMIT aborts the block; no further chunks are emitted.
- Byte mapping: rate byte k goes to chunk k/25, bits [(k%25)*8+7 : (k%25)*8]. Chunk bytes at k ≥ RATE_BYTES are always 0.
- Transfer: a beat is transferred when in_valid && in_ready. in_ready=1 only in FILL.
- FILL state:
  - Each transferred beat with in_bvalid=1 writes in_data to byte[count], then count+1.
  - Transfer without in_last, and count reaches RATE_BYTES → go to WAIT. The block is full and not the last block.
  - Transfer with in_last:
    - Let p = count after writing the byte, if any.
    - If p < RATE_BYTES: byte[p] ^= DSBYTE and byte[RATE_BYTES-1] ^= 8'h80. If p = RATE_BYTES-1, both land on one byte, giving 8'h86. Mark the block last and go to WAIT.
    - If p = RATE_BYTES: the current block is emitted unpadded as non-last, and a pad_pending flag is set.
- WAIT state:
  - Stay while the gap counter is nonzero.
  - Then go to EMIT and load the gap counter with GAP_CYCLES-1.
  - The gap counter decrements every cycle it is nonzero, in any state.
- EMIT state:
  - 8 consecutive cycles with pushout=1 and doutix=0,1,…,7.
  - blk_first = first_flag, blk_last = block-last, both constant across the 8 chunks.
  - Chunk 0 appears on the first cycle after entering EMIT; no bubbles.
- After chunk 7:
  - Clear the buffer and set count=0.
  - first_flag = block-last ? 1 : 0.
  - If pad_pending: build a pad-only block (byte0=DSBYTE, byte[RATE_BYTES-1]^=8'h80), mark it last, clear pad_pending, go to WAIT.
  - Otherwise go to FILL.
- Outputs are registered. dout=0 when pushout=0.
- There is no backpressure on the output side; the downstream stage must always accept.
- An end-only beat (in_bvalid=0, in_last=1) at count=0 produces a pad-only block. For a new message this is the empty-message hash input.

Test Plan:
- "abc" = bytes 61,62,63 then in_last on 63.
  - Expect one block: chunk0=200'h06636261, chunk5=200'h8000000000000000000000, all other chunks 0.
  - Expect blk_first=blk_last=1, doutix 0..7 on consecutive cycles.
- Empty message: single end-only beat.
  - Expect chunk0=200'h06, chunk5=200'h8000000000000000000000, others 0, blk_first=blk_last=1.
- 135 bytes of 0x00, last on byte 135.
  - Expect chunk5 byte 10 (bits [87:80]) = 8'h86 and chunk0..4 all 0.
- 136 bytes of 0xFF, last on byte 136.
  - Block A: first=1, last=0; chunks 0..4 all-ones, chunk5=200'hFF_FFFF_FFFF_FFFF_FFFF_FFFF, chunks 6..7 zero.
  - Block B: first=0, last=1, pad-only as in the empty-message case.
  - The chunk0 of B starts exactly GAP_CYCLES cycles after chunk0 of A.
- Assert reset low during EMIT at doutix=3.
  - pushout drops immediately.
  - After release, in_ready=1 and a fresh "abc" produces the expected block with blk_first=1.
- Hold in_valid low for 10 cycles mid-message (after 50 bytes of a 60-byte message).
  - Output matches the gap-free case.
  - in_ready stays 1 throughout FILL.
